adc_decimator: RTL

//  Parametrised successor to the fixed downsampling stage between the ADC capture block and the output register.

---
 rtl/adc_decimator_if.sv | 25 ++
 rtl/adc_decimator.sv | 107 ++++++++++
 2 files changed

// File: rtl/adc_decimator_if.sv
// Sample stream, run-time configuration and reduced output of the ADC decimator.
interface adc_decimator_if #(
  parameter int unsigned pWidth = 8
);
  logic [pWidth-1:0] iData;
  logic              iData_Valid;
  logic [4:0]        iRatioLog2;
  logic [1:0]        iMode;
  logic              iSync;
  logic [pWidth-1:0] oData;
  logic              oData_Valid;
  logic [4:0]        oBlockCfg;

  // Decimator side
  modport slave (
    input  iData, iData_Valid, iRatioLog2, iMode, iSync,
    output oData, oData_Valid, oBlockCfg
  );

  // Sample source / consumer side
  modport master (
    output iData, iData_Valid, iRatioLog2, iMode, iSync,
    input  oData, oData_Valid, oBlockCfg
  );
endinterface

// File: rtl/adc_decimator.sv
// Reduces the ADC sample stream by a run-time ratio 2^k using first-sample, mean, max or min.
// Ratio and mode latch only at block boundaries, on sync, or during reset.
module adc_decimator #(
  parameter int unsigned pWidth   = 8,
  parameter int unsigned pMaxLog2 = 15
) (
  input  logic             iClk,
  input  logic             iRst,
  adc_decimator_if.slave   io_bus
);
  localparam int unsigned AccW = pWidth + pMaxLog2;
  localparam logic [4:0]  MaxK = 5'(pMaxLog2);

  logic [4:0]          r_k;
  logic [1:0]          r_mode;
  logic [pMaxLog2-1:0] r_count;
  logic [AccW-1:0]     r_acc;
  logic [pWidth-1:0]   r_max;
  logic [pWidth-1:0]   r_min;
  logic [pWidth-1:0]   r_first;
  logic [pWidth-1:0]   r_data;
  logic                r_valid;

  logic [4:0]          w_k_in;
  logic                w_last_cur;
  logic                w_restart;
  logic [4:0]          w_k_eff;
  logic [1:0]          w_mode_eff;
  logic [pMaxLog2-1:0] w_cnt_eff;
  logic                w_first;
  logic                w_last;
  logic                w_cfg_load;
  logic [AccW-1:0]     w_acc_new;
  logic [pWidth-1:0]   w_max_new;
  logic [pWidth-1:0]   w_min_new;
  logic [pWidth-1:0]   w_first_new;
  logic [pWidth-1:0]   w_mean;
  logic [pWidth-1:0]   w_result;

  // Block position, effective config and per-block running values for the current sample
  always_comb begin
    w_k_in     = (io_bus.iRatioLog2 > MaxK) ? MaxK : io_bus.iRatioLog2;
    // A sample that completes the running block takes priority over a simultaneous sync,
    // so it is never also counted as the first sample of the next block.
    w_last_cur = io_bus.iData_Valid &&
                 (r_count == ~({pMaxLog2{1'b1}} << r_k));
    w_restart  = io_bus.iSync && !w_last_cur;
    w_k_eff    = w_restart ? w_k_in : r_k;
    w_mode_eff = w_restart ? io_bus.iMode : r_mode;
    w_cnt_eff  = w_restart ? '0 : r_count;
    w_first    = (w_cnt_eff == '0);
    w_last     = io_bus.iData_Valid &&
                 (w_cnt_eff == ~({pMaxLog2{1'b1}} << w_k_eff));
    w_cfg_load = w_last || io_bus.iSync;

    w_acc_new   = w_first ? AccW'(io_bus.iData) : r_acc + AccW'(io_bus.iData);
    w_max_new   = (w_first || io_bus.iData > r_max) ? io_bus.iData : r_max;
    w_min_new   = (w_first || io_bus.iData < r_min) ? io_bus.iData : r_min;
    w_first_new = w_first ? io_bus.iData : r_first;
    w_mean      = pWidth'(w_acc_new >> w_k_eff);

    w_result = w_first_new;
    unique case (w_mode_eff)
      2'd0:    w_result = w_first_new;
      2'd1:    w_result = w_mean;
      2'd2:    w_result = w_max_new;
      default: w_result = w_min_new;
    endcase
  end

  // Config latch, sample counter, block accumulators and registered output
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_k     <= w_k_in;
      r_mode  <= io_bus.iMode;
      r_count <= '0;
      r_acc   <= '0;
      r_max   <= '0;
      r_min   <= '0;
      r_first <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        r_data <= w_result;
      end
      if (w_cfg_load) begin
        r_k    <= w_k_in;
        r_mode <= io_bus.iMode;
      end
      if (io_bus.iData_Valid) begin
        r_count <= w_last ? '0 : w_cnt_eff + pMaxLog2'(1);
        r_acc   <= w_acc_new;
        r_max   <= w_max_new;
        r_min   <= w_min_new;
        r_first <= w_first_new;
      end else if (io_bus.iSync) begin
        r_count <= '0;
      end
    end
  end

  assign io_bus.oData       = r_data;
  assign io_bus.oData_Valid = r_valid;
  assign io_bus.oBlockCfg   = r_k;
endmodule
